// File: rtl/cordic_pkg.sv
// Shared encodings and constants for the CORDIC gain-compensation stage.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic signed [1:0] MODE_HYPERBOLIC = -2'sd1;
    localparam logic signed [1:0] MODE_LINEAR     = 2'sd0;
    localparam logic signed [1:0] MODE_CIRCULAR   = 2'sd1;

    // Inverse CORDIC gains; quantised by the user to its own fixed-point format.
    localparam real INV_K_CIRC = 0.607252935;
    localparam real INV_K_HYP  = 1.207497068;

endpackage

// File: rtl/cordic_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read and push-while-full when popping.
module cordic_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push_s, do_pop_s;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; a pop frees the head slot so a full FIFO can still take a push.
    always_comb begin
        do_pop_s  = i_pop && !o_empty;
        do_push_s = i_push && (!o_full || do_pop_s);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + (AW+1)'(1'b1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + (AW+1)'(1'b1)) : rd_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/cordic_gain_comp.sv
// Buffers CORDIC results and multiplies x/y of un-rotated circular/hyperbolic
// entries by the inverse CORDIC gain using a serial shift-add multiplier.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int INTEGER_BITS    = 3,
    parameter int FRACTIONAL_BITS = 30,
    parameter int FIFO_DEPTH      = 8,
    localparam int BITS           = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [BITS-1:0] i_x,
    input  logic [BITS-1:0] i_y,
    input  logic [BITS-1:0] i_z,
    input  logic [1:0]      i_mode,
    input  logic            i_rot_en,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [BITS-1:0] o_x,
    output logic [BITS-1:0] o_y,
    output logic [BITS-1:0] o_z,
    output logic [1:0]      o_mode,
    output logic            o_rot_en,
    output logic            o_overflow,
    output logic            o_empty
);
    localparam int ENTRY_W = 3 * BITS + 3;
    localparam int ACC_W   = 2 * BITS;
    localparam int CW      = $clog2(BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

    localparam longint K_CIRC_L = longint'(INV_K_CIRC * (2.0 ** FRACTIONAL_BITS));
    localparam longint K_HYP_L  = longint'(INV_K_HYP * (2.0 ** FRACTIONAL_BITS));
    localparam logic [BITS-1:0] K_CIRC = BITS'(K_CIRC_L);
    localparam logic [BITS-1:0] K_HYP  = BITS'(K_HYP_L);

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1'b1) << (FRACTIONAL_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAX_C   = ACC_W'({1'b0, {(BITS-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] MIN_C   = ~MAX_C;

    // Round half up, drop the fraction, clamp to the signed output range.
    function automatic logic [BITS-1:0] round_sat(input logic signed [ACC_W-1:0] prod);
        logic signed [ACC_W-1:0] shifted;
        shifted = (prod + ROUND_C) >>> FRACTIONAL_BITS;
        if (shifted > MAX_C) begin
            return MAX_C[BITS-1:0];
        end else if (shifted < MIN_C) begin
            return MIN_C[BITS-1:0];
        end else begin
            return shifted[BITS-1:0];
        end
    endfunction

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic signed [ACC_W-1:0] mcand_x_q, mcand_x_d, mcand_y_q, mcand_y_d;
    logic signed [ACC_W-1:0] sum_x_s, sum_y_s;
    logic [BITS-1:0]         k_q, k_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    o_valid_q, o_valid_d;
    logic [BITS-1:0]         o_x_q, o_x_d, o_y_q, o_y_d, o_z_q, o_z_d;
    logic [1:0]              o_mode_q, o_mode_d;
    logic                    o_rot_en_q, o_rot_en_d;
    logic                    overflow_q, overflow_d;

    logic [ENTRY_W-1:0] head_s;
    logic [BITS-1:0]    head_x_s, head_y_s, head_z_s;
    logic [1:0]         head_mode_s;
    logic               head_rot_s, scale_s;
    logic               pop_s, fifo_full_s, fifo_empty_s;

    cordic_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_valid),
        .i_data  ({i_x, i_y, i_z, i_mode, i_rot_en}),
        .i_pop   (pop_s),
        .o_data  (head_s),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s)
    );

    assign {head_x_s, head_y_s, head_z_s, head_mode_s, head_rot_s} = head_s;
    assign scale_s = !head_rot_s && ((head_mode_s == MODE_CIRCULAR) || (head_mode_s == MODE_HYPERBOLIC));

    // FSM next state, serial multiplier step and output word selection.
    always_comb begin
        state_d    = state_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        mcand_x_d  = mcand_x_q;
        mcand_y_d  = mcand_y_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        o_valid_d  = o_valid_q;
        o_x_d      = o_x_q;
        o_y_d      = o_y_q;
        o_z_d      = o_z_q;
        o_mode_d   = o_mode_q;
        o_rot_en_d = o_rot_en_q;
        pop_s      = 1'b0;
        sum_x_s    = acc_x_q + (k_q[0] ? mcand_x_q : {ACC_W{1'b0}});
        sum_y_s    = acc_y_q + (k_q[0] ? mcand_y_q : {ACC_W{1'b0}});

        case (state_q)
            ST_IDLE: begin
                pop_s = !fifo_empty_s;
            end
            ST_MUL: begin
                acc_x_d   = sum_x_s;
                acc_y_d   = sum_y_s;
                mcand_x_d = {mcand_x_q[ACC_W-2:0], 1'b0};
                mcand_y_d = {mcand_y_q[ACC_W-2:0], 1'b0};
                k_d       = {1'b0, k_q[BITS-1:1]};
                cnt_d     = cnt_q + CW'(1'b1);
                if (cnt_q == CNT_LAST) begin
                    o_x_d     = round_sat(sum_x_s);
                    o_y_d     = round_sat(sum_y_s);
                    o_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    state_d   = ST_MUL;
                end
            end
            ST_OUT: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    pop_s     = !fifo_empty_s;
                    state_d   = ST_IDLE;
                end else begin
                    o_valid_d = 1'b1;
                end
            end
            default: begin
                o_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // A pop from IDLE or a completed OUT loads the next entry in the same cycle.
        if (pop_s) begin
            o_z_d      = head_z_s;
            o_mode_d   = head_mode_s;
            o_rot_en_d = head_rot_s;
            if (scale_s) begin
                acc_x_d   = '0;
                acc_y_d   = '0;
                mcand_x_d = {{BITS{head_x_s[BITS-1]}}, head_x_s};
                mcand_y_d = {{BITS{head_y_s[BITS-1]}}, head_y_s};
                k_d       = (head_mode_s == MODE_CIRCULAR) ? K_CIRC : K_HYP;
                cnt_d     = '0;
                o_valid_d = 1'b0;
                state_d   = ST_MUL;
            end else begin
                o_x_d     = head_x_s;
                o_y_d     = head_y_s;
                o_valid_d = 1'b1;
                state_d   = ST_OUT;
            end
        end else begin
            cnt_d = cnt_d;
        end

        overflow_d = overflow_q || (i_valid && fifo_full_s && !pop_s);
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            mcand_x_q  <= '0;
            mcand_y_q  <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            o_valid_q  <= 1'b0;
            o_x_q      <= '0;
            o_y_q      <= '0;
            o_z_q      <= '0;
            o_mode_q   <= 2'b00;
            o_rot_en_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            mcand_x_q  <= mcand_x_d;
            mcand_y_q  <= mcand_y_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            o_valid_q  <= o_valid_d;
            o_x_q      <= o_x_d;
            o_y_q      <= o_y_d;
            o_z_q      <= o_z_d;
            o_mode_q   <= o_mode_d;
            o_rot_en_q <= o_rot_en_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_x        = o_x_q;
    assign o_y        = o_y_q;
    assign o_z        = o_z_q;
    assign o_mode     = o_mode_q;
    assign o_rot_en   = o_rot_en_q;
    assign o_overflow = overflow_q;
    assign o_empty    = fifo_empty_s && (state_q == ST_IDLE);

endmodule
